// File: rtl/shot_logic.sv
// Shot resolution for the light-gun game: fire-edge detection, hitbox test,
// per-round shot budget, saturating score and muzzle-flash/cooldown lockout.
module shot_logic #(
  parameter int DUCK_W          = 64,
  parameter int DUCK_H          = 64,
  parameter int SHOTS           = 3,
  parameter int FLASH_FRAMES    = 6,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk_slw,
  input  logic        rst,
  input  logic        fire_btn,
  input  logic        round_start,
  input  logic [10:0] sniper_x,
  input  logic [10:0] sniper_y,
  input  logic [10:0] duck_x,
  input  logic [10:0] duck_y,
  input  logic        duck_alive,
  output logic        hit,
  output logic        miss,
  output logic [1:0]  shots_left,
  output logic [9:0]  score,
  output logic        flash
);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    FLASH,
    COOLDOWN,
    EMPTY
  } state_t;

  localparam logic [11:0] BOX_W      = 12'(DUCK_W);
  localparam logic [11:0] BOX_H      = 12'(DUCK_H);
  localparam logic [4:0]  FLASH_LOAD = 5'(FLASH_FRAMES - 1);
  localparam logic [4:0]  COOL_LOAD  = 5'(COOLDOWN_FRAMES - 1);
  localparam logic [1:0]  SHOT_LOAD  = 2'(SHOTS);
  localparam logic [9:0]  SCORE_MAX  = 10'd999;

  state_t      state;
  logic [4:0]  timer;
  logic        fire_q;
  logic        fire_edge;
  logic        on_target;
  logic [11:0] sx, sy, x_lo, y_lo, x_hi, y_hi;

  // Bounds are widened to 12 bits so a duck near the right/bottom edge of
  // the 11-bit coordinate space never wraps its far edge back to zero.
  always_comb begin
    sx        = {1'b0, sniper_x};
    sy        = {1'b0, sniper_y};
    x_lo      = {1'b0, duck_x};
    y_lo      = {1'b0, duck_y};
    x_hi      = x_lo + BOX_W;
    y_hi      = y_lo + BOX_H;
    fire_edge = fire_btn & ~fire_q;
    on_target = duck_alive && (sx >= x_lo) && (sx < x_hi) &&
                (sy >= y_lo) && (sy < y_hi);
  end

  always_ff @(posedge clk_slw) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      fire_q     <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      flash      <= 1'b0;
      shots_left <= '0;
      score      <= '0;
    end else begin
      fire_q <= fire_btn;
      hit    <= 1'b0;
      miss   <= 1'b0;
      if (round_start) begin
        // A new round wins over a coincident shot; that shot is dropped.
        state      <= READY;
        shots_left <= SHOT_LOAD;
        timer      <= '0;
        flash      <= 1'b0;
      end else begin
        unique case (state)
          IDLE, EMPTY: flash <= 1'b0;
          READY: begin
            if (fire_edge && shots_left != 2'd0) begin
              hit        <= on_target;
              miss       <= ~on_target;
              shots_left <= shots_left - 2'd1;
              timer      <= FLASH_LOAD;
              flash      <= 1'b1;
              state      <= FLASH;
              if (on_target && score != SCORE_MAX)
                score <= score + 10'd1;
            end
          end
          FLASH: begin
            if (timer == 5'd0) begin
              timer <= COOL_LOAD;
              flash <= 1'b0;
              state <= COOLDOWN;
            end else begin
              timer <= timer - 5'd1;
            end
          end
          COOLDOWN: begin
            if (timer == 5'd0)
              state <= (shots_left != 2'd0) ? READY : EMPTY;
            else
              timer <= timer - 5'd1;
          end
          default: begin
            state <= IDLE;
            flash <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_logic.sv
// Randomised and directed bench for shot_logic against a lockout-countdown
// reference model.
module tb_shot_logic;

  localparam int DW = 64;
  localparam int DH = 64;
  localparam int NS = 3;
  localparam int FF = 6;
  localparam int CF = 15;

  logic        clk_slw = 1'b0;
  logic        rst = 1'b1, fire_btn = 1'b0, round_start = 1'b0, duck_alive = 1'b1;
  logic [10:0] sniper_x = '0, sniper_y = '0, duck_x = '0, duck_y = '0;
  logic        hit, miss, flash;
  logic [1:0]  shots_left;
  logic [9:0]  score;

  int total = 0;
  int bad   = 0;

  // Reference model: round active flag, shot budget, score and a single
  // lockout countdown covering flash plus cooldown.
  bit m_active, m_prev, m_hit, m_miss, m_flash;
  int m_shots, m_score, m_busy;

  logic [14:0] got, exp;

  shot_logic #(
    .DUCK_W(DW), .DUCK_H(DH), .SHOTS(NS),
    .FLASH_FRAMES(FF), .COOLDOWN_FRAMES(CF)
  ) dut (
    .clk_slw(clk_slw), .rst(rst), .fire_btn(fire_btn), .round_start(round_start),
    .sniper_x(sniper_x), .sniper_y(sniper_y), .duck_x(duck_x), .duck_y(duck_y),
    .duck_alive(duck_alive), .hit(hit), .miss(miss), .shots_left(shots_left),
    .score(score), .flash(flash)
  );

  always #5 clk_slw = ~clk_slw;

  function automatic void model_edge();
    bit edge_, inb;
    int sx, sy, dx, dy;
    if (rst) begin
      m_active = 0; m_prev = 0; m_hit = 0; m_miss = 0; m_flash = 0;
      m_shots = 0; m_score = 0; m_busy = 0;
    end else begin
      edge_  = fire_btn && !m_prev;
      m_prev = fire_btn;
      m_hit  = 0;
      m_miss = 0;
      if (round_start) begin
        m_active = 1; m_shots = NS; m_busy = 0; m_flash = 0;
      end else if (m_active && m_busy == 0 && m_shots > 0 && edge_) begin
        sx = int'(sniper_x); sy = int'(sniper_y);
        dx = int'(duck_x);   dy = int'(duck_y);
        inb = duck_alive && sx >= dx && sx < dx + DW && sy >= dy && sy < dy + DH;
        m_hit   = inb;
        m_miss  = !inb;
        if (inb && m_score < 999) m_score++;
        m_shots--;
        m_busy  = FF + CF;
        m_flash = 1;
      end else begin
        if (m_busy > 0) m_busy--;
        m_flash = (m_busy > CF);
      end
    end
  endfunction

  function automatic logic [14:0] model_vec();
    return {m_hit, m_miss, m_flash, 2'(m_shots), 10'(m_score)};
  endfunction

  task automatic step();
    @(posedge clk_slw);
    model_edge();
    #1;
  endtask

  task automatic wait_out();
    repeat (FF + CF) step();
  endtask

  task automatic start_round();
    round_start = 1'b1;
    step();
    round_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    got = {hit, miss, flash, shots_left, score};
    total++;
    if (got !== 15'h0) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, 15'h0); end
    rst = 1'b0;
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    step();
    got = {hit, miss, flash, shots_left, score}; exp = model_vec();
    total++;
    if (got !== exp || got !== 15'h0) begin bad++; $display("FAIL idle_fire got=%h exp=%h", got, exp); end
  endtask

  task automatic test_centre_hit();
    int fl;
    duck_x = 11'd600; duck_y = 11'd380; duck_alive = 1'b1;
    sniper_x = 11'd640; sniper_y = 11'd400;
    start_round();
    total++;
    if (shots_left !== 2'd3) begin bad++; $display("FAIL centre_load got=%0d exp=3", shots_left); end
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    got = {hit, miss, flash, shots_left, score};
    total++;
    if (got !== {1'b1, 1'b0, 1'b1, 2'd2, 10'd1}) begin
      bad++; $display("FAIL centre_hit got=%h exp=%h", got, {1'b1, 1'b0, 1'b1, 2'd2, 10'd1});
    end
    fl = 1;
    for (int i = 0; i < FF + CF + 2; i++) begin
      step();
      if (flash === 1'b1) fl++;
      got = {hit, miss, flash, shots_left, score}; exp = model_vec();
      total++;
      if (got !== exp) begin bad++; $display("FAIL centre_cycle%0d got=%h exp=%h", i, got, exp); end
    end
    total++;
    if (fl != FF) begin bad++; $display("FAIL centre_flash_len got=%0d exp=%0d", fl, FF); end
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    total++;
    if (hit !== 1'b1 || shots_left !== 2'd1) begin
      bad++; $display("FAIL centre_ready got=%b/%0d exp=1/1", hit, shots_left);
    end
    wait_out();
  endtask

  task automatic test_boundaries();
    int bx[5] = '{600, 663, 664, 640, 599};
    int by[5] = '{380, 443, 400, 444, 400};
    bit bh[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    duck_x = 11'd600; duck_y = 11'd380; duck_alive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_round();
      sniper_x = 11'(bx[i]); sniper_y = 11'(by[i]);
      fire_btn = 1'b1;
      step();
      fire_btn = 1'b0;
      got = {hit, miss, flash, shots_left, score}; exp = model_vec();
      total++;
      if (hit !== bh[i] || miss !== !bh[i] || got !== exp) begin
        bad++; $display("FAIL bound_%0d_%0d got=%h exp=%h hit_exp=%b", bx[i], by[i], got, exp, bh[i]);
      end
      wait_out();
    end
  endtask

  task automatic test_dead_lockout();
    duck_x = 11'd600; duck_y = 11'd380; duck_alive = 1'b0;
    sniper_x = 11'd640; sniper_y = 11'd400;
    start_round();
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    total++;
    if (hit !== 1'b0 || miss !== 1'b1) begin bad++; $display("FAIL dead_duck got=%b%b exp=01", hit, miss); end
    step();
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    total++;
    if (hit !== 1'b0 || miss !== 1'b0 || shots_left !== 2'd2) begin
      bad++; $display("FAIL flash_lock got=%b%b/%0d exp=00/2", hit, miss, shots_left);
    end
    repeat (FF) step();
    fire_btn = 1'b1;
    step();
    total++;
    if (hit !== 1'b0 || miss !== 1'b0 || flash !== 1'b0 || shots_left !== 2'd2) begin
      bad++; $display("FAIL cool_lock got=%b%b%b/%0d exp=000/2", hit, miss, flash, shots_left);
    end
    for (int i = 0; i < CF + 2; i++) begin
      step();
      got = {hit, miss, flash, shots_left, score}; exp = model_vec();
      total++;
      if (got !== exp || shots_left !== 2'd2) begin bad++; $display("FAIL held_fire%0d got=%h exp=%h", i, got, exp); end
    end
    fire_btn = 1'b0;
    step();
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    total++;
    if (miss !== 1'b1 || shots_left !== 2'd1) begin
      bad++; $display("FAIL refire got=%b/%0d exp=1/1", miss, shots_left);
    end
    duck_alive = 1'b1;
    wait_out();
  endtask

  task automatic test_exhaustion();
    sniper_x = 11'd620; sniper_y = 11'd390;
    start_round();
    for (int k = 0; k < NS; k++) begin
      fire_btn = 1'b1;
      step();
      fire_btn = 1'b0;
      total++;
      if (shots_left !== 2'(NS - 1 - k) || hit !== 1'b1) begin
        bad++; $display("FAIL exhaust_shot%0d got=%0d/%b exp=%0d/1", k, shots_left, hit, NS - 1 - k);
      end
      wait_out();
    end
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    got = {hit, miss, flash, shots_left, score}; exp = model_vec();
    total++;
    if (got !== exp || hit !== 1'b0 || miss !== 1'b0) begin bad++; $display("FAIL empty_fire got=%h exp=%h", got, exp); end
    start_round();
    got = {hit, miss, flash, shots_left, score}; exp = model_vec();
    total++;
    if (got !== exp || shots_left !== 2'd3) begin bad++; $display("FAIL empty_restart got=%h exp=%h", got, exp); end
  endtask

  task automatic test_saturation();
    int guard = 0;
    duck_alive = 1'b1; sniper_x = 11'd610; sniper_y = 11'd400;
    while (m_score < 999 && guard < 1100) begin
      guard++;
      start_round();
      fire_btn = 1'b1;
      step();
      fire_btn = 1'b0;
      got = {hit, miss, flash, shots_left, score}; exp = model_vec();
      total++;
      if (got !== exp) begin bad++; $display("FAIL sat_fill%0d got=%h exp=%h", guard, got, exp); end
      wait_out();
    end
    start_round();
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    total++;
    if (hit !== 1'b1 || score !== 10'd999) begin bad++; $display("FAIL sat_hold got=%b/%0d exp=1/999", hit, score); end
    wait_out();
    // round_start coinciding with a READY fire edge
    fire_btn = 1'b1; round_start = 1'b1;
    step();
    fire_btn = 1'b0; round_start = 1'b0;
    total++;
    if (hit !== 1'b0 || miss !== 1'b0 || shots_left !== 2'd3) begin
      bad++; $display("FAIL priority got=%b%b/%0d exp=00/3", hit, miss, shots_left);
    end
  endtask

  task automatic test_reset_mid();
    sniper_x = 11'd640; sniper_y = 11'd400;
    start_round();
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got = {hit, miss, flash, shots_left, score};
    total++;
    if (got !== 15'h0) begin bad++; $display("FAIL rst_flash got=%h exp=%h", got, 15'h0); end
    start_round();
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    repeat (FF + 3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    got = {hit, miss, flash, shots_left, score}; exp = model_vec();
    total++;
    if (got !== exp || got !== 15'h0) begin bad++; $display("FAIL rst_cool got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random();
    int off;
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      round_start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) == 0) fire_btn = ~fire_btn;
      if ($urandom_range(0, 19) == 0) begin
        duck_x = 11'($urandom_range(0, 2047));
        duck_y = 11'($urandom_range(0, 2047));
      end
      duck_alive = ($urandom_range(0, 4) != 0);
      off = int'(duck_x) + $urandom_range(0, DW + 16) - 8;
      sniper_x = 11'((off < 0) ? 0 : (off > 2047) ? 2047 : off);
      off = int'(duck_y) + $urandom_range(0, DH + 16) - 8;
      sniper_y = 11'((off < 0) ? 0 : (off > 2047) ? 2047 : off);
      step();
      got = {hit, miss, flash, shots_left, score}; exp = model_vec();
      total++;
      if (got !== exp) begin bad++; $display("FAIL random%0d got=%h exp=%h", i, got, exp); end
    end
    rst = 1'b0; round_start = 1'b0; fire_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_centre_hit();
    test_boundaries();
    test_dead_lockout();
    test_exhaustion();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
